team_08_dino_draw: RTL and testbench
====================================

TEAM_08_DINO_DRAW -- requirements
Module: team_08_dino_draw

Interface
REQ-001 SHALL have parameter DINO_X, default 9'd20, screen column of the sprite's left edge.
REQ-002 SHALL have parameter DINO_W, default 8'd10, sprite width in pixels.
REQ-003 SHALL have parameter DINO_H, default 8'd12, sprite height in pixels.
REQ-004 SHALL have parameter BASE_ROW, default 8'd220, screen row that corresponds to dinoY = 0.
REQ-005 SHALL have parameter FG_COLOR, default 16'h07E0, RGB565 sprite colour.
REQ-006 SHALL have parameter BG_COLOR, default 16'hFFFF, RGB565 background colour.
REQ-007 SHALL have port clk, input, 1 bit, system clock, rising edge.
REQ-008 SHALL have port nRst, input, 1 bit, reset, asynchronous, active-low.
REQ-009 SHALL have port state, input, state_t, game state (IDLE, RUN, WIN, OVER).
REQ-010 SHALL have port dinoY, input, 8 bits, dino height; larger values are higher on screen; 101 is the floor.
REQ-011 SHALL have port dinoMovement, input, 1 bit, level request to redraw; held high until drawDoneDino.
REQ-012 SHALL have port pixAck, input, 1 bit, LCD writer accepted the presented pixel.
REQ-013 SHALL have port pixValid, output, 1 bit, pixel write request.
REQ-014 SHALL have port pixX, output, 9 bits, pixel column.
REQ-015 SHALL have port pixY, output, 8 bits, pixel row.
REQ-016 SHALL have port pixColor, output, 16 bits, RGB565 pixel colour.
REQ-017 SHALL have port drawDoneDino, output, 1 bit, one-cycle pulse when a redraw completes.
REQ-018 SHALL have port busy, output, 1 bit, high whenever the FSM is not in WAIT.

Function
REQ-019 FSM SHALL have the states WAIT, ERASE, DRAW and DONE, with state, row counter and column counter all registered.
REQ-020 In WAIT, the FSM SHALL start a frame when dinoMovement == 1 and state == RUN, capturing newY <= dinoY and clearing the row and column counters; it SHALL otherwise stay in WAIT.
REQ-021 On a start, the FSM SHALL go to ERASE if newY != lastY, else directly to DRAW (erase skipped).
REQ-022 The top row of a rectangle SHALL be topRow = BASE_ROW - Y, computed mod 256 (8-bit wrap, no saturation).
REQ-023 ERASE SHALL use Y = lastY and pixColor = BG_COLOR; DRAW SHALL use Y = newY and pixColor = FG_COLOR.
REQ-024 Pixel coordinates SHALL be pixX = DINO_X + col and pixY = topRow + row, with col 0..DINO_W-1 and row 0..DINO_H-1.
REQ-025 Scan order SHALL be row-major, with col as the inner index.
REQ-026 pixValid SHALL be high in ERASE and DRAW and low in WAIT and DONE.
REQ-027 pixX, pixY and pixColor SHALL hold stable while pixValid == 1 and pixAck == 0.
REQ-028 A pixel SHALL be transferred on a rising edge where pixValid == 1 and pixAck == 1; the next pixel SHALL be presented in the following cycle, with pixValid allowed to stay high continuously.
REQ-029 No pixel SHALL be skipped or repeated.
REQ-030 When the last pixel of ERASE (col == DINO_W-1, row == DINO_H-1) is transferred, the FSM SHALL clear the counters and go to DRAW.
REQ-031 When the last pixel of DRAW is transferred, the FSM SHALL go to DONE.
REQ-032 In DONE, drawDoneDino SHALL be 1, decoded combinationally from the state register; lastY <= newY; next state WAIT. DONE SHALL last exactly one cycle.
REQ-033 Because upstream clears dinoMovement on the same edge that leaves DONE, WAIT SHALL NOT require a holdoff; any dinoMovement seen in WAIT SHALL be treated as a new request.
REQ-034 Changes of dinoY and dinoMovement during ERASE, DRAW or DONE SHALL be ignored; newY is frozen for the frame.
REQ-035 A change of state away from RUN mid-frame SHALL NOT abort the frame; the frame SHALL complete normally.
REQ-036 A frame SHALL take (ERASE ? 2 : 1) * DINO_W * DINO_H accepted pixels plus 1 DONE cycle.
REQ-037 With pixAck tied high, drawDoneDino SHALL assert exactly 2*W*H + 1 cycles after the start edge when erase runs.

Reset
REQ-038 On nRst == 0, asynchronously: FSM = WAIT, lastY = 8'd101, newY = 8'd101, counters = 0, pixValid = 0, drawDoneDino = 0, busy = 0.
REQ-039 Reset SHALL take effect immediately, including mid-frame; the partial frame SHALL be abandoned.
REQ-040 After reset is released, the first edge with dinoMovement == 1 and state == RUN SHALL start a fresh frame.

Verification
REQ-041 Reset test: assert nRst low -> pixValid = 0, drawDoneDino = 0, busy = 0; then dinoMovement = 1 with dinoY = 101 in RUN -> ERASE skipped, 120 FG pixels at rows 119..130, columns 20..29, then a one-cycle done pulse.
REQ-042 Jump frame test: pixAck = 1, state = RUN, dinoY = 112 after lastY = 101 -> 120 BG pixels at rows 119..130, then 120 FG pixels at rows 108..119, each in row-major order; drawDoneDino asserts 241 cycles after the start edge.
REQ-043 Backpressure test: pixAck = 0 for 5 cycles on the 3rd pixel -> pixX, pixY and pixColor are unchanged over those 5 cycles; the total transfer count is still 240 with no duplicates.
REQ-044 Gating test: dinoMovement = 1 while state is IDLE, WIN or OVER -> pixValid stays 0, busy stays 0, and no done pulse occurs.
REQ-045 Mid-frame test: dinoY changes and state goes to OVER during DRAW -> all pixels use the captured newY, and the frame completes with a done pulse.
REQ-046 Reset-abort test: pull nRst low on the 50th pixel of DRAW -> all outputs go to their reset values at once, and lastY = 101.

Source files
------------

// File: rtl/team_08_dino_draw.sv
// Dino sprite renderer: on a redraw request, erases the old sprite rectangle
// (only if the height changed) and then draws the new one, one handshaked pixel at a time.
module team_08_dino_draw #(
    parameter logic [8:0]  DINO_X   = 9'd20,
    parameter logic [7:0]  DINO_W   = 8'd10,
    parameter logic [7:0]  DINO_H   = 8'd12,
    parameter logic [7:0]  BASE_ROW = 8'd220,
    parameter logic [15:0] FG_COLOR = 16'h07E0,
    parameter logic [15:0] BG_COLOR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [1:0]  state,
    input  logic [7:0]  dinoY,
    input  logic        dinoMovement,
    input  logic        pixAck,
    output logic        pixValid,
    output logic [8:0]  pixX,
    output logic [7:0]  pixY,
    output logic [15:0] pixColor,
    output logic        drawDoneDino,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, WIN, OVER} state_t;
    typedef enum logic [1:0] {WAIT, ERASE, DRAW, DONE} fsm_t;

    localparam logic [7:0] FLOOR_Y = 8'd101;

    fsm_t       fsm_q, fsm_d;
    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;
    logic [7:0] newY_q, newY_d;
    logic [7:0] lastY_q, lastY_d;
    logic [7:0] rectY;
    logic       last_col, last_pix, xfer;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fsm_q   <= WAIT;
            row_q   <= '0;
            col_q   <= '0;
            newY_q  <= FLOOR_Y;
            lastY_q <= FLOOR_Y;
        end else begin
            fsm_q   <= fsm_d;
            row_q   <= row_d;
            col_q   <= col_d;
            newY_q  <= newY_d;
            lastY_q <= lastY_d;
        end
    end

    assign last_col = (col_q == DINO_W - 8'd1);
    assign last_pix = last_col && (row_q == DINO_H - 8'd1);
    assign xfer     = pixValid && pixAck;

    always_comb begin
        fsm_d   = fsm_q;
        row_d   = row_q;
        col_d   = col_q;
        newY_d  = newY_q;
        lastY_d = lastY_q;
        case (fsm_q)
            WAIT: begin
                if (dinoMovement && state == RUN) begin
                    newY_d = dinoY;
                    row_d  = '0;
                    col_d  = '0;
                    fsm_d  = (dinoY != lastY_q) ? ERASE : DRAW;
                end
            end
            ERASE, DRAW: begin
                // Row-major walk; wrapping to (0,0) on the last pixel doubles as the ERASE->DRAW clear.
                if (xfer) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = last_pix ? '0 : row_q + 8'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                    if (last_pix) fsm_d = (fsm_q == ERASE) ? DRAW : DONE;
                end
            end
            DONE: begin
                lastY_d = newY_q;
                fsm_d   = WAIT;
            end
            default: fsm_d = WAIT;
        endcase
    end

    assign rectY        = (fsm_q == ERASE) ? lastY_q : newY_q;
    assign pixValid     = (fsm_q == ERASE) || (fsm_q == DRAW);
    assign pixX         = DINO_X + {1'b0, col_q};
    assign pixY         = BASE_ROW - rectY + row_q;
    assign pixColor     = (fsm_q == ERASE) ? BG_COLOR : FG_COLOR;
    assign drawDoneDino = (fsm_q == DONE);
    assign busy         = (fsm_q != WAIT);

endmodule

// File: tb/tb_team_08_dino_draw.sv
// Randomized self-checking bench for team_08_dino_draw: expected pixel streams are
// generated from the rectangle geometry and compared at every presented pixel.
module tb_team_08_dino_draw;

    localparam logic [8:0]  DINO_X = 9'd20;
    localparam int          W      = 10;
    localparam int          H      = 12;
    localparam int          BASE   = 220;
    localparam logic [15:0] FG     = 16'h07E0;
    localparam logic [15:0] BG     = 16'hFFFF;
    localparam logic [1:0]  S_IDLE = 2'd0, S_RUN = 2'd1, S_WIN = 2'd2, S_OVER = 2'd3;

    logic        clk = 1'b0;
    logic        nRst;
    logic [1:0]  gstate;
    logic [7:0]  dinoY;
    logic        dinoMovement;
    logic        pixAck;
    logic        pixValid;
    logic [8:0]  pixX;
    logic [7:0]  pixY;
    logic [15:0] pixColor;
    logic        drawDoneDino;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  model_last;
    logic [32:0] expq[$];

    always #5 clk = ~clk;

    team_08_dino_draw #(
        .DINO_X(9'd20), .DINO_W(8'd10), .DINO_H(8'd12),
        .BASE_ROW(8'd220), .FG_COLOR(16'h07E0), .BG_COLOR(16'hFFFF)
    ) dut (
        .clk(clk), .nRst(nRst), .state(gstate), .dinoY(dinoY),
        .dinoMovement(dinoMovement), .pixAck(pixAck), .pixValid(pixValid),
        .pixX(pixX), .pixY(pixY), .pixColor(pixColor),
        .drawDoneDino(drawDoneDino), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Rectangle at height y: rows start at (BASE - y) mod 256, columns at DINO_X.
    task automatic push_rect(input logic [7:0] y, input logic [15:0] c);
        for (int r = 0; r < H; r++) begin
            for (int cc = 0; cc < W; cc++) begin
                logic [8:0] x;
                logic [7:0] py;
                x  = DINO_X + 9'(cc);
                py = 8'(BASE - int'(y) + r);
                expq.push_back({x, py, c});
            end
        end
    endtask

    // ack_mode: 0 = always accept, 1 = random accept, 2 = 5-cycle stall on 3rd pixel
    task automatic run_frame(input logic [7:0] y, input int ack_mode, input bit disturb, input int abort_at);
        int  n, xfers, stall, total, erase_cnt;
        bit  done_seen, erase, ack;
        expq.delete();
        erase = (y != model_last);
        if (erase) push_rect(model_last, BG);
        push_rect(y, FG);
        total     = expq.size();
        erase_cnt = erase ? W * H : 0;
        n = 0; xfers = 0; stall = 0; done_seen = 0;
        @(negedge clk);
        dinoY = y; gstate = S_RUN; dinoMovement = 1'b1; pixAck = 1'b1;
        while (!done_seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (drawDoneDino) begin
                done_seen = 1;
                chk("done_pixvalid", 64'(pixValid), 64'd0);
                chk("done_xfers", 64'(xfers), 64'(total));
                if (ack_mode == 0) chk("done_latency", 64'(n), 64'(total + 1));
                dinoMovement = 1'b0;
                model_last   = y;
                @(negedge clk);
                chk("done_one_cycle", 64'(drawDoneDino), 64'd0);
                chk("busy_after_done", 64'(busy), 64'd0);
            end else begin
                chk("busy_in_frame", 64'(busy), 64'd1);
                chk("pixvalid_in_frame", 64'(pixValid), 64'd1);
                if (expq.size() == 0) chk("extra_pixel", 64'd1, 64'd0);
                else chk("pixel", 64'({pixX, pixY, pixColor}), 64'(expq[0]));
                if (abort_at >= 0 && xfers == erase_cnt + abort_at) begin
                    nRst = 1'b0;
                    #1;
                    chk("abort_pixvalid", 64'(pixValid), 64'd0);
                    chk("abort_done", 64'(drawDoneDino), 64'd0);
                    chk("abort_busy", 64'(busy), 64'd0);
                    model_last   = 8'd101;
                    dinoMovement = 1'b0;
                    @(negedge clk);
                    chk("abort_held_busy", 64'(busy), 64'd0);
                    nRst = 1'b1;
                    return;
                end
                case (ack_mode)
                    0: ack = 1'b1;
                    1: ack = ($urandom_range(0, 3) != 0);
                    default: begin
                        ack = !(xfers == 2 && stall < 5);
                        if (!ack) stall++;
                    end
                endcase
                pixAck = ack;
                if (ack && expq.size() != 0) begin
                    void'(expq.pop_front());
                    xfers++;
                end
                if (disturb && xfers > erase_cnt + 10) begin
                    dinoY        = 8'($urandom);
                    gstate       = S_OVER;
                    dinoMovement = 1'($urandom);
                end
            end
        end
        if (!done_seen) chk("frame_timeout", 64'd0, 64'd1);
    endtask

    task automatic gate_test(input logic [1:0] st);
        @(negedge clk);
        gstate = st; dinoMovement = 1'b1; dinoY = 8'($urandom_range(102, 200));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("gate_pixvalid", 64'(pixValid), 64'd0);
            chk("gate_busy", 64'(busy), 64'd0);
            chk("gate_done", 64'(drawDoneDino), 64'd0);
        end
        dinoMovement = 1'b0;
    endtask

    initial begin
        nRst = 1'b0; gstate = S_IDLE; dinoY = 8'd101; dinoMovement = 1'b0; pixAck = 1'b0;
        model_last = 8'd101;
        repeat (2) @(negedge clk);
        chk("reset_pixvalid", 64'(pixValid), 64'd0);
        chk("reset_done", 64'(drawDoneDino), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        nRst = 1'b1;

        run_frame(8'd101, 0, 0, -1);
        run_frame(8'd112, 0, 0, -1);
        run_frame(8'd101, 2, 0, -1);
        gate_test(S_IDLE);
        gate_test(S_WIN);
        gate_test(S_OVER);
        run_frame(8'd130, 1, 1, -1);
        run_frame(8'd140, 1, 0, 49);
        run_frame(8'd101, 0, 0, -1);
        run_frame(8'd230, 0, 0, -1);
        run_frame(8'd230, 1, 0, -1);
        for (int k = 0; k < 6; k++) begin
            logic [7:0] y;
            case ($urandom_range(0, 3))
                0: y = model_last;
                1: y = 8'd0;
                default: y = 8'($urandom_range(101, 255));
            endcase
            run_frame(y, int'($urandom_range(0, 1)), 1'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
